// File: rtl/fir_sequencer.sv
// Moore control FSM for a time-multiplexed K-tap FIR: accept sample, LOAD, K x COMPUTE, hold result until out_ready.
// Optional `FIR_SEQ_TAP_CHECK_EN: checks tap_last against an internal cycle count and flags a sticky err.
module fir_sequencer #(
   parameter int K     = 8,
   parameter int CHK_W = $clog2(K + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   output logic in_ready,
   output logic shift_en,
   output logic tap_start,
   output logic tap_en,
   input  logic tap_last,
   output logic acc_clr,
   output logic acc_en,
   output logic out_valid,
   input  logic out_ready,
   output logic busy,
   output logic err
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LOAD    = 2'd1;
   localparam logic [1:0] S_COMPUTE = 2'd2;
   localparam logic [1:0] S_OUTPUT  = 2'd3;

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       err_set;

`ifdef FIR_SEQ_TAP_CHECK_EN
   logic [CHK_W-1:0] chk_cnt;
   logic             chk_last;
   logic             err_q;

   // chk_cnt holds the number of COMPUTE cycles already completed
   assign chk_last = (chk_cnt == CHK_W'(K - 1));
   assign err_set  = (state == S_COMPUTE) && (tap_last != chk_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_cnt <= '0;
      end else if (state == S_LOAD) begin
         chk_cnt <= '0;
      end else if (state == S_COMPUTE) begin
         chk_cnt <= chk_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (err_set) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err_set = 1'b0;
   assign err     = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (in_valid) state_nxt = S_LOAD;
         S_LOAD:    state_nxt = S_COMPUTE;
         S_COMPUTE: begin
            // a bad tap sequence abandons the partial result
            if (err_set) begin
               state_nxt = S_IDLE;
            end else if (tap_last) begin
               state_nxt = S_OUTPUT;
            end
         end
         S_OUTPUT:  if (out_ready) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   assign in_ready  = (state == S_IDLE);
   assign shift_en  = (state == S_LOAD);
   assign tap_start = (state == S_LOAD);
   assign acc_clr   = (state == S_LOAD);
   assign tap_en    = (state == S_COMPUTE);
   assign acc_en    = (state == S_COMPUTE);
   assign out_valid = (state == S_OUTPUT);
   assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_fir_sequencer.sv
// Bench for fir_sequencer: emulated tap counter, phase-count reference model, directed and random traffic.
module tb_fir_sequencer;
   localparam int K = 8;

   logic clk = 1'b0;
   logic rst, in_valid, in_ready, shift_en, tap_start, tap_en, tap_last;
   logic acc_clr, acc_en, out_valid, out_ready, busy, err;

   always #5 clk = ~clk;

   fir_sequencer #(.K(K)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .shift_en(shift_en), .tap_start(tap_start), .tap_en(tap_en), .tap_last(tap_last),
      .acc_clr(acc_clr), .acc_en(acc_en), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .err(err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Tap counter emulation; tap_mode 0 = correct, 1 = tap_last at 4th cycle, 2 = tap_last never
   int tap_idx;
   int tap_mode;
   always @(posedge clk or posedge rst) begin
      if (rst) tap_idx <= 0;
      else if (tap_start) tap_idx <= 0;
      else if (tap_en) tap_idx <= (tap_idx + 1) % K;
   end

   always_comb begin
      tap_last = 1'b0;
      case (tap_mode)
         0:       tap_last = (tap_idx == K - 1);
         1:       tap_last = (tap_idx == 3);
         default: tap_last = 1'b0;
      endcase
   end

   // Reference: t = cycles since accept (0 idle, 1 load, 2..K+1 compute, >=K+2 output)
   int t;
   bit model_on = 0;
   always @(posedge clk or posedge rst) begin
      if (rst) t <= 0;
      else if (t == 0) begin
         if (in_valid) t <= 1;
      end
      else if (t <= K + 1) t <= t + 1;
      else if (out_ready) t <= 0;
   end

   always @(negedge clk) begin
      if (model_on && !rst) begin
         check_val("m_in_ready", in_ready, t == 0);
         check_val("m_shift_en", shift_en, t == 1);
         check_val("m_tap_start", tap_start, t == 1);
         check_val("m_acc_clr", acc_clr, t == 1);
         check_val("m_tap_en", tap_en, t >= 2 && t <= K + 1);
         check_val("m_acc_en", acc_en, t >= 2 && t <= K + 1);
         check_val("m_out_valid", out_valid, t >= K + 2);
         check_val("m_busy", busy, t != 0);
         check_val("m_err", err, 0);
      end
   end

   // Event monitor
   int cyc = 0;
   int n_shift, n_tstart, n_aclr, n_tap, n_acc, n_ov, n_out;
   int acc_q[$];
   int ov_rise_q[$];
   int rdy_rise_q[$];
   logic ov_prev = 1'b0;
   logic rdy_prev = 1'b0;

   always @(posedge clk) begin
      cyc++;
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (shift_en) n_shift++;
      if (tap_start) n_tstart++;
      if (acc_clr) n_aclr++;
      if (tap_en) n_tap++;
      if (acc_en) n_acc++;
      if (out_valid) n_ov++;
      if (out_valid && out_ready) n_out++;
   end

   always @(negedge clk) begin
      if (out_valid && !ov_prev) ov_rise_q.push_back(cyc);
      if (in_ready && !rdy_prev) rdy_rise_q.push_back(cyc);
      ov_prev = out_valid;
      rdy_prev = in_ready;
   end

   task automatic clear_counts();
      n_shift = 0; n_tstart = 0; n_aclr = 0; n_tap = 0; n_acc = 0; n_ov = 0; n_out = 0;
      acc_q.delete(); ov_rise_q.delete(); rdy_rise_q.delete();
   endtask

   task automatic send_one();
      int n = 0;
      while (!in_ready && n < 60) begin @(negedge clk); n++; end
      check_val("send_wait", in_ready, 1);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input int max);
      int n = 0;
      while (!out_valid && n < max) begin @(negedge clk); n++; end
      check_val("out_wait", out_valid, 1);
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (busy && n < max) begin @(negedge clk); n++; end
      check_val("idle_wait", busy, 0);
   endtask

   task automatic check_reset_vals(input string pfx);
      check_val({pfx, "_in_ready"}, in_ready, 1);
      check_val({pfx, "_shift_en"}, shift_en, 0);
      check_val({pfx, "_tap_start"}, tap_start, 0);
      check_val({pfx, "_tap_en"}, tap_en, 0);
      check_val({pfx, "_acc_clr"}, acc_clr, 0);
      check_val({pfx, "_acc_en"}, acc_en, 0);
      check_val({pfx, "_out_valid"}, out_valid, 0);
      check_val({pfx, "_busy"}, busy, 0);
      check_val({pfx, "_err"}, err, 0);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; tap_mode = 0;
      #1;
      check_reset_vals("rst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_counts();
      model_on = 1;

      // single sample
      out_ready = 1'b1;
      send_one();
      wait_idle(40);
      repeat (2) @(negedge clk);
      check_val("single_shift", n_shift, 1);
      check_val("single_tstart", n_tstart, 1);
      check_val("single_aclr", n_aclr, 1);
      check_val("single_tap_en", n_tap, K);
      check_val("single_acc_en", n_acc, K);
      check_val("single_ov", n_ov, 1);
      check_val("single_out", n_out, 1);
      check_val("single_nq", (acc_q.size() == 1) && (ov_rise_q.size() == 1) && (rdy_rise_q.size() == 1), 1);
      if (acc_q.size() == 1 && ov_rise_q.size() == 1 && rdy_rise_q.size() == 1) begin
         check_val("single_lat", ov_rise_q[0] - acc_q[0], K + 1);
         // in_ready is high in the (K+3)th cycle, i.e. from edge K+2 after accept
         check_val("single_rdy", rdy_rise_q[0] - acc_q[0], K + 2);
      end

      // backpressure: 5 stalled edges, in_valid pending across the output handshake
      clear_counts();
      out_ready = 1'b0;
      send_one();
      wait_out(40);
      in_valid = 1'b1;
      repeat (5) @(negedge clk);
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      wait_idle(40);
      check_val("bp_ov_cycles", n_ov, 6 + 1);
      check_val("bp_out", n_out, 2);
      check_val("bp_shift", n_shift, 2);
      if (acc_q.size() == 2) check_val("bp_reaccept", acc_q[1] - acc_q[0], K + 1 + 6 + 1);
      else check_val("bp_nacc", acc_q.size(), 2);

      // streaming
      begin
         int n = 0;
         clear_counts();
         out_ready = 1'b1;
         in_valid = 1'b1;
         while (acc_q.size() < 4 && n < 100) begin @(negedge clk); n++; end
         in_valid = 1'b0;
         wait_idle(40);
         check_val("str_nacc", acc_q.size(), 4);
         check_val("str_shift", n_shift, 4);
         check_val("str_out", n_out, 4);
         check_val("str_ov", n_ov, 4);
         for (int i = 1; i < acc_q.size(); i++) check_val("str_period", acc_q[i] - acc_q[i-1], K + 3);
      end

      // random traffic
      clear_counts();
      repeat (400) begin
         @(negedge clk);
         in_valid = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_idle(40);
      check_val("rnd_delivered", n_out, acc_q.size());
      check_val("rnd_shift", n_shift, acc_q.size());

      // reset in COMPUTE at tap_index 3
      begin
         int n = 0;
         clear_counts();
         send_one();
         while (!(tap_en && tap_idx == 3) && n < 40) begin @(negedge clk); n++; end
         check_val("mid_reach", tap_idx, 3);
         #1 rst = 1'b1;
         #1 check_reset_vals("mid");
         @(negedge clk);
         rst = 1'b0;
         repeat (15) @(negedge clk);
         check_val("mid_no_ov", n_ov, 0);
         clear_counts();
         send_one();
         wait_idle(40);
         check_val("mid_next_tap", n_tap, K);
         check_val("mid_next_out", n_out, 1);
      end

      // tap-sequence faults
      model_on = 0;
      out_ready = 1'b1;
      tap_mode = 1;
      clear_counts();
      send_one();
      repeat (20) @(negedge clk);
`ifdef FIR_SEQ_TAP_CHECK_EN
      check_val("early_err", err, 1);
      check_val("early_busy", busy, 0);
      check_val("early_ov", n_ov, 0);
      check_val("early_tap", n_tap, 4);
      tap_mode = 0;
      clear_counts();
      send_one();
      wait_idle(40);
      check_val("after_err_out", n_out, 1);
      check_val("after_err_sticky", err, 1);
      pulse_rst();
      check_val("err_clr1", err, 0);
      tap_mode = 2;
      clear_counts();
      send_one();
      repeat (20) @(negedge clk);
      check_val("never_err", err, 1);
      check_val("never_busy", busy, 0);
      check_val("never_ov", n_ov, 0);
      check_val("never_tap", n_tap, K);
      pulse_rst();
      check_val("err_clr2", err, 0);
      tap_mode = 0;
      clear_counts();
      send_one();
      wait_idle(40);
      check_val("post_out", n_out, 1);
      check_val("post_err", err, 0);
`else
      check_val("early_err", err, 0);
      check_val("early_out", n_out, 1);
      check_val("early_tap", n_tap, 4);
      check_val("early_busy", busy, 0);
      if (acc_q.size() == 1 && ov_rise_q.size() == 1) check_val("early_lat", ov_rise_q[0] - acc_q[0], 5);
      else check_val("early_nq", ov_rise_q.size(), 1);
      tap_mode = 2;
      clear_counts();
      send_one();
      repeat (30) @(negedge clk);
      check_val("never_busy", busy, 1);
      check_val("never_tap_en", tap_en, 1);
      check_val("never_ov", n_ov, 0);
      check_val("never_err", err, 0);
      pulse_rst();
      check_val("never_rst_busy", busy, 0);
      tap_mode = 0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
